// File: rtl/ysyx_22041207_stage_reg.sv
// Pipeline stage register: one payload bus, valid/ready handshake, optional skid entry, flush, stall counter.
// Latency: payload accepted at an active edge is on out_data right after that edge (1 edge minimum).
// Backpressure: SKID=1 absorbs one extra beat behind a registered in_ready; SKID=0 passes out_ready straight to in_ready.
module ysyx_22041207_stage_reg #(
   parameter int WIDTH   = 256,
   parameter int SKID    = 1,
   parameter int NEGEDGE = 1,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_nxt;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_nxt;
   logic             rdy_q;
   logic             in_fire;
   logic             out_fire;
   logic             act_clk;

   // Every register in the stage runs on the same edge; NEGEDGE picks the
   // falling edge so the stage lines up with the existing pipeline timing.
   assign act_clk  = (NEGEDGE != 0) ? ~clk : clk;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // State and payload registers; the ready flag is decoded from the next
   // state so in_ready never sees out_ready combinationally when SKID=1.
   always_ff @(posedge act_clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b1;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
         rdy_q  <= (state_nxt != TWO);
      end
   end

   // Next-state and next-payload: flush wins, vacated entries are zeroed so
   // bubbles carry inactive control fields downstream.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         state_nxt = EMPTY;
         main_nxt  = '0;
         skid_nxt  = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt = ONE;
                  main_nxt  = in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_nxt = in_data;
               end else if (in_fire) begin
                  // Without a skid entry in_ready implies out_ready here,
                  // so this branch is only reachable with SKID=1.
                  if (SKID != 0) begin
                     state_nxt = TWO;
                     skid_nxt  = in_data;
                  end
               end else if (out_fire) begin
                  state_nxt = EMPTY;
                  main_nxt  = '0;
               end
            end
            TWO: begin
               if (out_fire) begin
                  state_nxt = ONE;
                  main_nxt  = skid_q;
                  skid_nxt  = '0;
               end
            end
            default: begin
               state_nxt = EMPTY;
               main_nxt  = '0;
               skid_nxt  = '0;
            end
         endcase
      end
   end

   // Output decode: valid/data straight from registers; in_ready registered
   // with the skid entry, combinational pass-through without it.
   always_comb begin
      out_valid = (state != EMPTY);
      out_data  = main_q;
      if (SKID != 0) begin
         in_ready = rdy_q;
      end else begin
         in_ready = (state == EMPTY) | out_ready;
      end
   end

   // Stall counter: counts edges where a held payload is refused, sticks at all-ones.
   always_ff @(posedge act_clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if ((state != EMPTY) && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ysyx_22041207_stage_reg.sv
// Bench for the stage register: three instances (skid, no-skid on inverted clock, 4-bit counter).
// All active edges coincide with the falling edge of clk; inputs change at posedge+1.
// Expected payloads go into one scoreboard queue; a monitor pops on every out handshake.
module tb_ysyx_22041207_stage_reg;
   localparam int W = 8;

   logic clk = 1'b0;
   logic clkb;
   logic rst_n;

   logic [2:0]        iv;
   logic [2:0]        orr;
   logic [2:0]        fl;
   logic [2:0][W-1:0] id;

   logic ir0, ir1, ir2;
   logic ov0, ov1, ov2;
   logic [W-1:0] od0, od1, od2;
   logic [31:0] sc_a, sc_b;
   logic [3:0]  sc_c;

   logic [2:0]        ir;
   logic [2:0]        ov;
   logic [2:0][W-1:0] od;

   logic [W-1:0] exp_q[$];
   int n_chk;
   int n_fail;

   assign clkb = ~clk;
   assign ir   = {ir2, ir1, ir0};
   assign ov   = {ov2, ov1, ov0};
   assign od   = {od2, od1, od0};

   always #5 clk = ~clk;

   ysyx_22041207_stage_reg #(.WIDTH(W), .SKID(1), .NEGEDGE(1), .CNT_W(32)) u_skid (
      .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir0),
      .in_data(id[0]), .out_valid(ov0), .out_ready(orr[0]), .out_data(od0), .stall_cnt(sc_a));

   ysyx_22041207_stage_reg #(.WIDTH(W), .SKID(0), .NEGEDGE(0), .CNT_W(32)) u_flow (
      .clk(clkb), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir1),
      .in_data(id[1]), .out_valid(ov1), .out_ready(orr[1]), .out_data(od1), .stall_cnt(sc_b));

   ysyx_22041207_stage_reg #(.WIDTH(W), .SKID(1), .NEGEDGE(1), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir2),
      .in_data(id[2]), .out_valid(ov2), .out_ready(orr[2]), .out_data(od2), .stall_cnt(sc_c));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat for one edge; acc is the hand-derived acceptance.
   task automatic offer(input int k, input logic [W-1:0] data, input logic acc, input logic rdy);
      iv[k]  = 1'b1;
      id[k]  = data;
      orr[k] = rdy;
      #1;
      chk($sformatf("in_ready dut%0d beat 0x%0h", k, data), {31'd0, ir[k]}, {31'd0, acc});
      if (acc) exp_q.push_back(data);
      cyc();
      iv[k] = 1'b0;
      id[k] = '0;
   endtask

   task automatic idle(input int k, input logic rdy, input int n);
      iv[k]  = 1'b0;
      orr[k] = rdy;
      repeat (n) cyc();
   endtask

   // Flush edge with a simultaneous offer; everything still held is dropped.
   task automatic flush_edge(input int k, input logic [W-1:0] data, input logic rdy);
      iv[k]  = 1'b1;
      id[k]  = data;
      orr[k] = rdy;
      fl[k]  = 1'b1;
      cyc();
      fl[k] = 1'b0;
      iv[k] = 1'b0;
      id[k] = '0;
      exp_q.delete();
   endtask

   // Monitor: pops the scoreboard on each out handshake, checks bubbles are zero.
   always begin : mon
      logic [W-1:0] e;
      @(posedge clk);
      #3;
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            if (ov[k] && orr[k]) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL out_unexpected dut%0d: got 0x%0h, expected no output", k, od[k]);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("out_data dut%0d", k), {24'd0, od[k]}, {24'd0, e});
               end
            end else if (!ov[k]) begin
               chk($sformatf("bubble_zero dut%0d", k), {24'd0, od[k]}, 32'd0);
            end
         end
      end
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      iv     = '0;
      orr    = 3'b111;
      fl     = '0;
      id     = '0;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      // reset state, asynchronous (no clock edge yet)
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst out_valid dut%0d", k), {31'd0, ov[k]}, 32'd0);
         chk($sformatf("rst out_data dut%0d", k), {24'd0, od[k]}, 32'd0);
         chk($sformatf("rst in_ready dut%0d", k), {31'd0, ir[k]}, 32'd1);
      end
      chk("rst stall_cnt a", sc_a, 32'd0);
      chk("rst stall_cnt b", sc_b, 32'd0);
      chk("rst stall_cnt c", {28'd0, sc_c}, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // first fill
      offer(0, 8'hA5, 1'b1, 1'b0);
      chk("fill out_valid", {31'd0, ov0}, 32'd1);
      chk("fill out_data", {24'd0, od0}, 32'h0000_00A5);
      idle(0, 1'b1, 1);
      chk("fill drained", {31'd0, ov0}, 32'd0);

      // streaming 1..16 on skid and no-skid instances
      for (int k = 0; k < 2; k++) begin
         for (int i = 1; i <= 16; i++) begin
            offer(k, W'(i), 1'b1, 1'b1);
            chk($sformatf("stream valid dut%0d beat %0d", k, i), {31'd0, ov[k]}, 32'd1);
            chk($sformatf("stream data dut%0d beat %0d", k, i), {24'd0, od[k]}, i);
         end
         idle(k, 1'b1, 1);
         chk($sformatf("stream end valid dut%0d", k), {31'd0, ov[k]}, 32'd0);
      end

      // skid fill: 0x11, 0x22 accepted under stall, 0x33 held off
      offer(0, 8'h11, 1'b1, 1'b0);
      chk("skid one data", {24'd0, od0}, 32'h11);
      offer(0, 8'h22, 1'b1, 1'b0);
      chk("skid two in_ready", {31'd0, ir0}, 32'd0);
      chk("skid two data", {24'd0, od0}, 32'h11);
      chk("skid stall 1", sc_a, 32'd1);
      offer(0, 8'h33, 1'b0, 1'b0);
      chk("skid stall 2", sc_a, 32'd2);
      offer(0, 8'h33, 1'b0, 1'b1);
      chk("skid pop data", {24'd0, od0}, 32'h22);
      chk("skid pop in_ready", {31'd0, ir0}, 32'd1);
      offer(0, 8'h33, 1'b1, 1'b1);
      chk("skid third data", {24'd0, od0}, 32'h33);
      idle(0, 1'b1, 1);
      chk("skid drained", {31'd0, ov0}, 32'd0);
      chk("skid stall final", sc_a, 32'd2);

      // flush in TWO with in_valid offered
      offer(2, 8'h44, 1'b1, 1'b0);
      offer(2, 8'h55, 1'b1, 1'b0);
      chk("flush pre in_ready", {31'd0, ir2}, 32'd0);
      flush_edge(2, 8'h66, 1'b0);
      chk("flush out_valid", {31'd0, ov2}, 32'd0);
      chk("flush out_data", {24'd0, od2}, 32'd0);
      chk("flush in_ready", {31'd0, ir2}, 32'd1);
      chk("flush stall_cnt", {28'd0, sc_c}, 32'd2);
      idle(2, 1'b1, 3);

      // flush with accepted in_fire and out_fire on the no-skid stage
      offer(1, 8'h77, 1'b1, 1'b0);
      flush_edge(1, 8'h88, 1'b1);
      chk("flush2 out_valid", {31'd0, ov1}, 32'd0);
      chk("flush2 out_data", {24'd0, od1}, 32'd0);
      chk("flush2 in_ready", {31'd0, ir1}, 32'd1);
      idle(1, 1'b1, 3);

      // combinational ready and bubble zeroing on the no-skid stage
      offer(1, 8'hFF, 1'b1, 1'b1);
      chk("bubble full data", {24'd0, od1}, 32'hFF);
      offer(1, 8'hEE, 1'b0, 1'b0);
      chk("bubble held data", {24'd0, od1}, 32'hFF);
      offer(1, 8'hEE, 1'b1, 1'b1);
      chk("bubble next data", {24'd0, od1}, 32'hEE);
      idle(1, 1'b1, 1);
      chk("bubble out_valid", {31'd0, ov1}, 32'd0);
      chk("bubble out_data", {24'd0, od1}, 32'd0);
      chk("bubble stall_cnt", sc_b, 32'd1);

      // 4-bit counter saturation: starts at 2, 20 stalled edges
      offer(2, 8'h99, 1'b1, 1'b0);
      idle(2, 1'b0, 12);
      chk("sat stall 14", {28'd0, sc_c}, 32'd14);
      idle(2, 1'b0, 8);
      chk("sat stall 15", {28'd0, sc_c}, 32'd15);
      idle(2, 1'b0, 3);
      chk("sat stall hold", {28'd0, sc_c}, 32'd15);
      idle(2, 1'b1, 1);
      chk("sat drained", {31'd0, ov2}, 32'd0);
      chk("sat stall after", {28'd0, sc_c}, 32'd15);

      idle(0, 1'b1, 2);
      chk("scoreboard drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
